// File: rtl/window_buffer.sv
// 3x3 RGB neighbourhood builder for a raster-order pixel stream.
// Two line buffers hold the previous rows; a 3x3 register window shifts on every accepted pixel.
module window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sof,
  input  logic             pixel_valid,
  input  logic [23:0]      pixel_in,
  output logic             window_valid,
  output logic [215:0]     pixelData,
  output logic [COL_W-1:0] center_col,
  output logic [ROW_W-1:0] center_row,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             accept;
  logic             emit;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;

  logic [23:0]      line_a [IMG_WIDTH];
  logic [23:0]      line_b [IMG_WIDTH];
  logic [23:0]      top_rd;
  logic [23:0]      mid_rd;

  logic [23:0]      win [9];
  logic [215:0]     win_next;

  // A sof-qualified pixel is always position (0,0), even mid-frame.
  assign accept  = pixel_valid && (sof || (state == ACTIVE));
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign emit    = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

  assign top_rd = line_b[cur_col];
  assign mid_rd = line_a[cur_col];

  assign win_next = {win[1], win[2], top_rd,
                     win[4], win[5], mid_rd,
                     win[7], win[8], pixel_in};

  // Line buffers: read-before-write at the same column, no reset so they map to RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_b[cur_col] <= mid_rd;
      line_a[cur_col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= top_rd;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= mid_rd;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      pixelData    <= '0;
      center_col   <= '0;
      center_row   <= '0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (emit) begin
        window_valid <= 1'b1;
        pixelData    <= win_next;
        center_col   <= cur_col - COL_W'(1);
        center_row   <= cur_row - ROW_W'(1);
      end
      if (accept) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          if (cur_row == ROW_LAST) begin
            row        <= '0;
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            row   <= cur_row + ROW_W'(1);
            state <= ACTIVE;
          end
        end else begin
          col   <= cur_col + COL_W'(1);
          row   <= cur_row;
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer on a 4x4 image: frame-image reference model plus literal checks.
module tb_window_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         sof = 1'b0;
  logic         pixel_valid = 1'b0;
  logic [23:0]  pixel_in = '0;
  logic         window_valid;
  logic [215:0] pixelData;
  logic [1:0]   center_col;
  logic [1:0]   center_row;
  logic         frame_done;

  int tests = 0;
  int fails = 0;

  window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .n_rst(n_rst), .sof(sof), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .window_valid(window_valid), .pixelData(pixelData),
    .center_col(center_col), .center_row(center_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: remembers every pixel of the current frame by (row, col) and
  // cuts the 3x3 neighbourhood straight out of that image.
  logic [23:0]  img [H][W];
  logic         m_active;
  int           mr, mc;
  logic         exp_valid, exp_fd;
  logic [215:0] exp_data;
  logic [1:0]   exp_cr, exp_cc;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active  <= 1'b0;
      mr        <= 0;
      mc        <= 0;
      exp_valid <= 1'b0;
      exp_fd    <= 1'b0;
      exp_data  <= '0;
      exp_cr    <= '0;
      exp_cc    <= '0;
    end else begin
      int r, c;
      logic [215:0] wv;
      logic [23:0]  px;
      exp_valid <= 1'b0;
      exp_fd    <= 1'b0;
      if (pixel_valid && (sof || m_active)) begin
        r = sof ? 0 : mr;
        c = sof ? 0 : mc;
        img[r][c] <= pixel_in;
        if (r >= 2 && c >= 2) begin
          wv = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              px = (i == 2 && j == 2) ? pixel_in : img[r-2+i][c-2+j];
              wv[215 - 24*(3*i+j) -: 24] = px;
            end
          exp_valid <= 1'b1;
          exp_data  <= wv;
          exp_cr    <= 2'(r - 1);
          exp_cc    <= 2'(c - 1);
        end
        if (r == H-1 && c == W-1) begin
          m_active <= 1'b0;
          exp_fd   <= 1'b1;
          mr       <= 0;
          mc       <= 0;
        end else begin
          m_active <= 1'b1;
          mr       <= (c == W-1) ? r + 1 : r;
          mc       <= (c == W-1) ? 0 : c + 1;
        end
      end
    end
  end

  int           win_cnt = 0;
  int           fd_cnt = 0;
  int           c12_cnt = 0;
  bit           got_first = 1'b0;
  logic [215:0] first_data;
  logic [1:0]   first_cr, first_cc;

  always @(negedge clk) begin
    chk("window_valid", 216'(window_valid), 216'(exp_valid));
    chk("frame_done", 216'(frame_done), 216'(exp_fd));
    chk("pixelData", pixelData, exp_data);
    chk("center_row", 216'(center_row), 216'(exp_cr));
    chk("center_col", 216'(center_col), 216'(exp_cc));
    if (window_valid) begin
      win_cnt++;
      if (center_row == 2'd1 && center_col == 2'd2) c12_cnt++;
      if (!got_first) begin
        got_first  = 1'b1;
        first_data = pixelData;
        first_cr   = center_row;
        first_cc   = center_col;
      end
    end
    if (frame_done) fd_cnt++;
  end

  task automatic drive(input logic s, input logic v, input logic [23:0] p);
    sof = s;
    pixel_valid = v;
    pixel_in = p;
    @(posedge clk);
    #1;
    sof = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 24'($urandom));
  endtask

  // gap: 0 continuous, 1 alternate valid/idle, 2 random idle runs. stop_at<0 sends the whole frame.
  task automatic send_frame(input bit pattern, input int gap, input int stop_at);
    for (int i = 0; i < W*H; i++) begin
      logic [23:0] p;
      if (i == stop_at) return;
      p = pattern ? {8'(i / W), 8'(i % W), 8'hA5} : 24'($urandom);
      drive(i == 0, 1'b1, p);
      if (gap == 1) idle(1);
      else if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic clear_counts();
    win_cnt = 0;
    fd_cnt = 0;
    c12_cnt = 0;
  endtask

  initial begin
    #3;
    chk("reset window_valid", 216'(window_valid), 216'd0);
    chk("reset pixelData", pixelData, 216'd0);
    chk("reset frame_done", 216'(frame_done), 216'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(2);

    // Valid pixels without sof are ignored after reset.
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 24'($urandom));
    idle(2);
    chk("no-sof windows", 216'(win_cnt), 216'd0);
    chk("no-sof frame_done", 216'(fd_cnt), 216'd0);

    clear_counts();
    got_first = 1'b0;
    send_frame(1'b1, 0, -1);
    idle(3);
    chk("frame1 windows", 216'(win_cnt), 216'd4);
    chk("frame1 frame_done", 216'(fd_cnt), 216'd1);
    chk("first win top-left", 216'(first_data[215:192]), 216'h0000A5);
    chk("first win centre", 216'(first_data[119:96]), 216'h0101A5);
    chk("first win bottom-right", 216'(first_data[23:0]), 216'h0202A5);
    chk("first win centre row", 216'(first_cr), 216'd1);
    chk("first win centre col", 216'(first_cc), 216'd1);

    clear_counts();
    send_frame(1'b1, 1, -1);
    idle(3);
    chk("toggle windows", 216'(win_cnt), 216'd4);
    chk("toggle frame_done", 216'(fd_cnt), 216'd1);

    // Restart at (2,3): only (1,1) of the old frame may appear.
    clear_counts();
    send_frame(1'b1, 0, 11);
    send_frame(1'b1, 0, -1);
    idle(3);
    chk("abort windows", 216'(win_cnt), 216'd5);
    chk("abort centre(1,2) count", 216'(c12_cnt), 216'd1);
    chk("abort frame_done", 216'(fd_cnt), 216'd1);

    // Async reset mid-frame after three windows.
    clear_counts();
    send_frame(1'b1, 0, 15);
    idle(1);
    chk("pre-reset windows", 216'(win_cnt), 216'd3);
    n_rst = 1'b0;
    #1;
    chk("mid-reset window_valid", 216'(window_valid), 216'd0);
    chk("mid-reset pixelData", pixelData, 216'd0);
    chk("mid-reset centre", 216'({center_row, center_col}), 216'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 24'($urandom));
    clear_counts();
    send_frame(1'b1, 0, -1);
    idle(3);
    chk("post-reset windows", 216'(win_cnt), 216'd4);

    clear_counts();
    send_frame(1'b0, 0, -1);
    send_frame(1'b0, 0, -1);
    idle(3);
    chk("back-to-back windows", 216'(win_cnt), 216'd8);
    chk("back-to-back frame_done", 216'(fd_cnt), 216'd2);

    // Randomised frames, gaps and aborts against the model.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) send_frame(1'b0, 2, $urandom_range(1, W*H-1));
      send_frame(1'b0, 2, -1);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 4));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
